cnn_argmax_counter: RTL and testbench

Post-processing stage directly downstream of the CNN memory/layer block. On `start` it scans the final fully-connected layer's logits from the output memory, which has 1-cycle synchronous-read latency. It selects the arg-max class, maps it to a card rank, and updates a Hi-Lo blackjack running count and a cards-seen counter. Results are held for software readback.

---
 rtl/cnn_argmax_counter.sv | 198 +++++++++++++++++++
 tb/tb_cnn_argmax_counter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_argmax_counter.sv
// cnn_argmax_counter: scans the final-layer logits from the output memory,
// picks the arg-max class and reports it as a card. When the CARD_COUNT_EN
// macro is defined, it also keeps a Hi-Lo running count and a cards-seen
// counter. Without the macro, both counters read as constant 0 and
// clear_count is ignored.
module cnn_argmax_counter #(
    parameter int N_CLASSES = 53,
    parameter int ADDR_W    = 19,
    parameter int BASE_ADDR = 0,
    parameter int THRESH    = -128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear_count,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              busy,
    output logic              done,
    output logic [5:0]        class_idx,
    output logic [7:0]        class_score,
    output logic              card_valid,
    output logic [7:0]        running_count,
    output logic [15:0]       cards_seen
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

    localparam logic [5:0]        LAST_IDX = 6'(N_CLASSES - 1);
    localparam logic [5:0]        N_CARDS  = 6'd52;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic signed [7:0] THRESH_S = 8'(THRESH);

    state_t            state_q, state_d;
    logic              launch;
    logic [5:0]        idx_q;
    logic [3:0]        rank_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              cmp_vld_q;
    logic [5:0]        cmp_idx_q;
    logic [3:0]        cmp_rank_q;
    logic [5:0]        best_idx_q, best_idx_d;
    logic [7:0]        best_score_q, best_score_d;
    logic [3:0]        best_rank_q, best_rank_d;
    logic              update;
    logic              card_valid_d;
    logic [5:0]        class_idx_q;
    logic [7:0]        class_score_q;
    logic              card_valid_q;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a start is only accepted in IDLE or DONE.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SCAN;
                    launch  = 1'b1;
                end
            end
            S_SCAN:  if (idx_q == LAST_IDX) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE: begin
                if (start) begin
                    state_d = S_SCAN;
                    launch  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy    = (state_q == S_SCAN) || (state_q == S_DRAIN);
    assign done    = (state_q == S_DONE);
    assign rd_addr = rd_addr_q;
    assign update  = (state_q == S_DRAIN);

    // Address/index walker. The rank counter wraps 12->0 alongside the index, so index mod 13 needs no divider.
    always_ff @(posedge clk) begin
        if (reset || launch) begin
            idx_q     <= '0;
            rank_q    <= '0;
            rd_addr_q <= BASE;
        end else if (state_q == S_SCAN && idx_q != LAST_IDX) begin
            idx_q     <= idx_q + 6'd1;
            rank_q    <= (rank_q == 4'd12) ? 4'd0 : rank_q + 4'd1;
            rd_addr_q <= rd_addr_q + 1'b1;
        end
    end

    // Delay the issued index by one cycle to line it up with the memory read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_vld_q  <= 1'b0;
            cmp_idx_q  <= '0;
            cmp_rank_q <= '0;
        end else begin
            cmp_vld_q  <= (state_q == S_SCAN);
            cmp_idx_q  <= idx_q;
            cmp_rank_q <= rank_q;
        end
    end

    // Running best: load on the first logit, then replace only on a strictly greater score.
    always_comb begin
        best_idx_d   = best_idx_q;
        best_score_d = best_score_q;
        best_rank_d  = best_rank_q;
        if (cmp_vld_q && (cmp_idx_q == 6'd0 ||
                          $signed(rd_data) > $signed(best_score_q))) begin
            best_idx_d   = cmp_idx_q;
            best_score_d = rd_data;
            best_rank_d  = cmp_rank_q;
        end
    end

    // Best-so-far registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            best_idx_q   <= '0;
            best_score_q <= '0;
            best_rank_q  <= '0;
        end else begin
            best_idx_q   <= best_idx_d;
            best_score_q <= best_score_d;
            best_rank_q  <= best_rank_d;
        end
    end

    // The last compare lands in DRAIN, so the results take the combinational best.
    assign card_valid_d = (best_idx_d < N_CARDS) && ($signed(best_score_d) >= THRESH_S);

    // Result registers, loaded on the DRAIN->DONE edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            class_idx_q   <= '0;
            class_score_q <= '0;
            card_valid_q  <= 1'b0;
        end else if (update) begin
            class_idx_q   <= best_idx_d;
            class_score_q <= best_score_d;
            card_valid_q  <= card_valid_d;
        end
    end

    assign class_idx   = class_idx_q;
    assign class_score = class_score_q;
    assign card_valid  = card_valid_q;

`ifdef CARD_COUNT_EN
    logic signed [1:0] hilo_delta;
    logic signed [8:0] count_sum;
    logic [7:0]        count_sat;
    logic [7:0]        running_count_q;
    logic [15:0]       cards_seen_q;

    // Hi-Lo weight: cards 2-6 count +1, 7-9 count 0, and ten through ace count -1.
    always_comb begin
        hilo_delta = -2'sd1;
        if (best_rank_d >= 4'd1 && best_rank_d <= 4'd5)      hilo_delta = 2'sd1;
        else if (best_rank_d >= 4'd6 && best_rank_d <= 4'd8) hilo_delta = 2'sd0;
        count_sum = $signed({running_count_q[7], running_count_q}) +
                    {{7{hilo_delta[1]}}, hilo_delta};
        count_sat = count_sum[7:0];
        if (count_sum > 9'sd127)       count_sat = 8'h7f;
        else if (count_sum < -9'sd128) count_sat = 8'h80;
    end

    // Counters; a clear wins over a coincident update.
    always_ff @(posedge clk) begin
        if (reset || clear_count) begin
            running_count_q <= '0;
            cards_seen_q    <= '0;
        end else if (update && card_valid_d) begin
            running_count_q <= count_sat;
            cards_seen_q    <= cards_seen_q + 16'd1;
        end
    end

    assign running_count = running_count_q;
    assign cards_seen    = cards_seen_q;
`else
    logic unused_count_inputs;
    assign unused_count_inputs = ^{clear_count, best_rank_q};
    assign running_count       = '0;
    assign cards_seen          = '0;
`endif

endmodule

// File: tb/tb_cnn_argmax_counter.sv
// Testbench for cnn_argmax_counter: table-driven scans, randomized scans
// against a reference model, and hand sequences for saturation, clear,
// ignored start and mid-scan reset. A second instance runs with THRESH=10.
module tb_cnn_argmax_counter;

    localparam int N = 53;

    logic        clk = 1'b0;
    logic        reset, start, clear_count;
    logic [18:0] rd_addr, rd_addr2;
    logic [7:0]  rd_data, rd_data2;
    logic        busy, done, card_valid;
    logic [5:0]  class_idx;
    logic [7:0]  class_score, running_count;
    logic [15:0] cards_seen;
    logic        busy2, done2, card_valid2;
    logic [5:0]  class_idx2;
    logic [7:0]  class_score2, running_count2;
    logic [15:0] cards_seen2;

    logic signed [7:0] mem [0:N-1];

    int n_cmp = 0;
    int n_fail = 0;
    int m_count = 0;
    int m_seen = 0;

    always #5 clk = ~clk;

    cnn_argmax_counter u_dut (
        .clk(clk), .reset(reset), .start(start), .clear_count(clear_count),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
        .class_idx(class_idx), .class_score(class_score), .card_valid(card_valid),
        .running_count(running_count), .cards_seen(cards_seen)
    );

    cnn_argmax_counter #(.THRESH(10)) u_dut_t (
        .clk(clk), .reset(reset), .start(start), .clear_count(clear_count),
        .rd_addr(rd_addr2), .rd_data(rd_data2), .busy(busy2), .done(done2),
        .class_idx(class_idx2), .class_score(class_score2), .card_valid(card_valid2),
        .running_count(running_count2), .cards_seen(cards_seen2)
    );

    // Output memory with 1-cycle read latency; garbage beyond the logits.
    always @(posedge clk) begin
        rd_data  <= (int'(rd_addr)  < N) ? mem[int'(rd_addr)]  : 8'($urandom);
        rd_data2 <= (int'(rd_addr2) < N) ? mem[int'(rd_addr2)] : 8'($urandom);
    end

    typedef struct {
        int hot1; int val1; int hot2; int val2; int bg;
        int exp_idx; int exp_score; bit exp_valid; bit exp_valid_t;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load(input int hot1, input int val1, input int hot2, input int val2, input int bg);
        for (int i = 0; i < N; i++) mem[i] = 8'(bg);
        mem[hot1] = 8'(val1);
        if (hot2 >= 0) mem[hot2] = 8'(val2);
    endtask

    // Reference arg-max: lowest index among the maximal scores.
    task automatic model_scan(input int thr, output int e_idx, output int e_score, output bit e_valid);
        e_idx   = 0;
        e_score = int'(mem[0]);
        for (int i = 1; i < N; i++)
            if (int'(mem[i]) > e_score) begin
                e_idx   = i;
                e_score = int'(mem[i]);
            end
        e_valid = (e_idx < 52) && (e_score >= thr);
    endtask

    // Reference Hi-Lo bookkeeping.
    task automatic model_count(input int idx, input bit valid, input bit clr);
`ifdef CARD_COUNT_EN
        int card;
        if (clr) begin
            m_count = 0;
            m_seen  = 0;
        end else if (valid) begin
            card   = idx % 13 + 1;
            m_seen = (m_seen + 1) % 65536;
            if (card >= 2 && card <= 6)      m_count = m_count + 1;
            else if (card == 1 || card >= 10) m_count = m_count - 1;
            if (m_count > 127)  m_count = 127;
            if (m_count < -128) m_count = -128;
        end
`else
        if (clr || valid || idx < 0) begin
            m_count = 0;
            m_seen  = 0;
        end
`endif
    endtask

    task automatic idle(input int n, output int ndone);
        ndone = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (done || done2) ndone++;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".busy"}, int'(busy), 0);
        check({tag, ".done"}, int'(done), 0);
        check({tag, ".class_idx"}, int'(class_idx), 0);
        check({tag, ".class_score"}, int'(class_score), 0);
        check({tag, ".card_valid"}, int'(card_valid), 0);
        check({tag, ".running_count"}, int'(running_count), 0);
        check({tag, ".cards_seen"}, int'(cards_seen), 0);
        check({tag, ".rd_addr"}, int'(rd_addr), 0);
    endtask

    // One scan: start is raised now (back-to-back if we sit in DONE);
    // optional start/clear/reset pulses are placed at given cycle numbers.
    task automatic run_scan(input int e_idx, input int e_score, input bit e_valid, input bit e_valid_t,
                            input int start_at, input int clr_at, input int rst_at, input string tag);
        int cyc, busy_n, addr_err, nd;
        bit got_done;
        cyc = 1; busy_n = 0; addr_err = 0; got_done = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!got_done && cyc <= 200) begin
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (busy) busy_n++;
                if (cyc <= N && int'(rd_addr) != cyc - 1) addr_err++;
                if (cyc == start_at) start = 1'b1;
                if (cyc == clr_at)   clear_count = 1'b1;
                if (cyc == rst_at)   reset = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                clear_count = 1'b0;
                if (reset) begin
                    reset = 1'b0;
                    m_count = 0;
                    m_seen  = 0;
                    check_reset_state({tag, ".rst"});
                    idle(70, nd);
                    check({tag, ".done_after_reset"}, nd, 0);
                    return;
                end
                cyc++;
            end
        end
        check({tag, ".done_cycle"}, cyc, 55);
        check({tag, ".busy_cycles"}, busy_n, 54);
        check({tag, ".addr_errors"}, addr_err, 0);
        check({tag, ".rd_addr_hold"}, int'(rd_addr), N - 1);
        check({tag, ".class_idx"}, int'(class_idx), e_idx);
        check({tag, ".class_score"}, int'($signed(class_score)), e_score);
        check({tag, ".card_valid"}, int'(card_valid), int'(e_valid));
        check({tag, ".t10_idx"}, int'(class_idx2), e_idx);
        check({tag, ".t10_valid"}, int'(card_valid2), int'(e_valid_t));
        model_count(e_idx, e_valid, clr_at == 54);
        check({tag, ".running_count"}, int'($signed(running_count)), m_count);
        check({tag, ".cards_seen"}, int'(cards_seen), m_seen);
    endtask

    initial begin
        vec_t tbl[8];
        int ei, es, nd, a, b, v;
        bit ev, evt;

        tbl[0] = '{17, 40, -1, 0, -5, 17, 40, 1'b1, 1'b1};
        tbl[1] = '{3, 90, 30, 90, 0, 3, 90, 1'b1, 1'b1};
        tbl[2] = '{52, 100, -1, 0, 0, 52, 100, 1'b0, 1'b0};
        tbl[3] = '{8, 5, -1, 0, -20, 8, 5, 1'b1, 1'b0};
        tbl[4] = '{0, -128, -1, 0, -128, 0, -128, 1'b1, 1'b0};
        tbl[5] = '{51, 127, -1, 0, -128, 51, 127, 1'b1, 1'b1};
        tbl[6] = '{10, 10, -1, 0, 9, 10, 10, 1'b1, 1'b1};
        tbl[7] = '{52, 20, 40, 20, 0, 40, 20, 1'b1, 1'b1};

        reset = 1'b1; start = 1'b0; clear_count = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_state("reset");

        // Table vectors, run back to back.
        for (int t = 0; t < 8; t++) begin
            load(tbl[t].hot1, tbl[t].val1, tbl[t].hot2, tbl[t].val2, tbl[t].bg);
            run_scan(tbl[t].exp_idx, tbl[t].exp_score, tbl[t].exp_valid, tbl[t].exp_valid_t,
                     0, 0, 0, $sformatf("vec%0d", t));
        end
        idle(5, nd);
        check("done_single_pulse", nd, 0);

        // Clear while idle.
        clear_count = 1'b1;
        @(posedge clk); #1 clear_count = 1'b0;
        model_count(0, 1'b0, 1'b1);
        check("idle_clear.running_count", int'($signed(running_count)), m_count);
        check("idle_clear.cards_seen", int'(cards_seen), m_seen);

        // Randomized scans with occasional forced ties.
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < N; i++) mem[i] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) begin
                a = $urandom_range(0, N - 1);
                b = $urandom_range(0, N - 1);
                v = $urandom_range(100, 127);
                mem[a] = 8'(v);
                mem[b] = 8'(v);
            end
            model_scan(-128, ei, es, ev);
            model_scan(10, ei, es, evt);
            run_scan(ei, es, ev, evt, 0, 0, 0, $sformatf("rand%0d", r));
        end

        // Saturation: 130 card-2 wins from a cleared count.
        load(1, 50, -1, 0, -1);
        clear_count = 1'b1;
        @(posedge clk); #1 clear_count = 1'b0;
        model_count(0, 1'b0, 1'b1);
        for (int s = 0; s < 130; s++) run_scan(1, 50, 1'b1, 1'b1, 0, 0, 0, "sat");
`ifdef CARD_COUNT_EN
        check("sat.final_count", int'($signed(running_count)), 127);
        check("sat.final_seen", int'(cards_seen), 130);
`else
        check("sat.final_count", int'($signed(running_count)), 0);
        check("sat.final_seen", int'(cards_seen), 0);
`endif

        // Clear coincident with the count update edge.
        run_scan(1, 50, 1'b1, 1'b1, 0, 54, 0, "clr_upd");
        check("clr_upd.zero_count", int'($signed(running_count)), 0);

        // Start in the middle of a scan is ignored.
        load(17, 40, -1, 0, -5);
        run_scan(17, 40, 1'b1, 1'b1, 20, 0, 0, "start20");
        idle(60, nd);
        check("start20.extra_done", nd, 0);

        // Build non-zero state, then reset mid-scan, then recover.
        run_scan(17, 40, 1'b1, 1'b1, 0, 0, 0, "pre_rst");
        run_scan(17, 40, 1'b1, 1'b1, 0, 0, 30, "rst30");
        run_scan(17, 40, 1'b1, 1'b1, 0, 0, 0, "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
